fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer for the pipeline CPU. Owns the PC, drives the

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 55 +++++
 rtl/fetch_ctrl.sv | 74 +++++++
 tb/tb_fetch_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default widths and opcode encodings.
package cpu_pkg;

   localparam int DEF_INSTR_W = 32;
   localparam int DEF_PC_W    = 10;
   localparam int OPC_HI      = 31;
   localparam int OPC_LO      = 28;

   localparam logic [3:0] OP_JUMP = 4'b1100;

   function automatic logic is_jump(input logic [DEF_INSTR_W-1:0] instr);
      return instr[OPC_HI:OPC_LO] == OP_JUMP;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer holding {instr, pc} entries.
// Head is read straight from the storage registers.
module fetch_fifo #(
   parameter  int W     = 42,
   parameter  int DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic          push,
   input  logic [W-1:0]  din,
   input  logic          pop,
   output logic [W-1:0]  head,
   output logic          valid,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= inc(wr_ptr);
         if (pop)  rd_ptr <= inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Storage cleared only on reset so the head reads zero afterwards.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push && !flush) begin
         mem[wr_ptr] <= din;
      end
   end

   assign head  = mem[rd_ptr];
   assign valid = (count != '0);

   assert property (@(posedge clk) disable iff (rst)
      !(push && !pop && !flush && count == CW'(DEPTH)));

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, folds jumps at fetch,
// buffers 1-cycle-latency memory responses and feeds decode.
module fetch_ctrl import cpu_pkg::*; #(
   parameter int              PC_W       = DEF_PC_W,
   parameter int              INSTR_W    = DEF_INSTR_W,
   parameter int              FIFO_DEPTH = 2,
   parameter logic [PC_W-1:0] RESET_PC   = '0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   output logic [PC_W-1:0]    mem_pc,
   input  logic [INSTR_W-1:0] mem_instr,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc,
   input  logic               redirect_v,
   input  logic [PC_W-1:0]    redirect_pc
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   logic                    inflight;
   logic [PC_W-1:0]         inflight_pc;
   logic [CW-1:0]           count;
   logic [CW:0]             credit;
   logic                    jump_hit;
   logic                    issue;
   logic                    pop;
   logic                    push;
   logic [INSTR_W+PC_W-1:0] head;

   assign pop      = out_valid & out_ready & ~redirect_v;
   assign push     = inflight & ~redirect_v;
   assign jump_hit = inflight & is_jump(mem_instr) & ~redirect_v;

   // Slots already claimed: buffered words plus the one in flight.
   assign credit = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
   assign issue  = run & ~redirect_v & ~jump_hit &
                   (credit < (CW+1)'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_pc      <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         inflight <= issue;
         if (issue) inflight_pc <= mem_pc;
         if (redirect_v)    mem_pc <= redirect_pc;
         else if (jump_hit) mem_pc <= mem_instr[PC_W-1:0];
         else if (issue)    mem_pc <= mem_pc + PC_W'(1);
      end
   end

   fetch_fifo #(
      .W     (INSTR_W + PC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (redirect_v),
      .push  (push),
      .din   ({mem_instr, inflight_pc}),
      .pop   (pop),
      .head  (head),
      .valid (out_valid),
      .count (count)
   );

   assign {out_instr, out_pc} = head;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a 1-cycle-latency program memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_ctrl;

   logic        clk;
   logic        rst;
   logic        run;
   logic [9:0]  mem_pc;
   logic [31:0] mem_instr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [9:0]  out_pc;
   logic        redirect_v;
   logic [9:0]  redirect_pc;

   int passed;
   int total;

   logic [31:0] pmem [1024];

   fetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .mem_pc      (mem_pc),
      .mem_instr   (mem_instr),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_instr   (out_instr),
      .out_pc      (out_pc),
      .redirect_v  (redirect_v),
      .redirect_pc (redirect_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) mem_instr <= pmem[mem_pc];

   function automatic logic [31:0] lin(input int i);
      return 32'h1000_0000 | 32'(i & 1023);
   endfunction

   task automatic restart();
      @(negedge clk);
      rst = 1'b1; run = 1'b0; redirect_v = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0; run = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid);
      else passed++;
      total++;
      if (out_pc !== 10'h000) $display("FAIL rst_pc: got %h want 000", out_pc);
      else passed++;
      total++;
      if (out_instr !== 32'h0) $display("FAIL rst_instr: got %h want 0", out_instr);
      else passed++;
      total++;
      if (mem_pc !== 10'h000) $display("FAIL rst_mem_pc: got %h want 000", mem_pc);
      else passed++;
   endtask

   task automatic test_linear();
      restart();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL lin_latency: got %b want 0", out_valid);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if ({out_valid, out_pc} !== {1'b1, 10'(k)})
            $display("FAIL lin_pc%0d: got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, 10'(k));
         else passed++;
         total++;
         if (out_instr !== lin(k))
            $display("FAIL lin_instr%0d: got %h want %h", k, out_instr, lin(k));
         else passed++;
      end
   endtask

   task automatic test_jump();
      pmem[3] = 32'hC000_0005;
      restart();
      repeat (5) @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h003})
         $display("FAIL jmp_pc3: got v=%b pc=%h want v=1 pc=003", out_valid, out_pc);
      else passed++;
      total++;
      if (out_instr !== 32'hC000_0005)
         $display("FAIL jmp_word: got %h want c0000005", out_instr);
      else passed++;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL jmp_bubble: got %b want 0", out_valid);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h005})
         $display("FAIL jmp_target: got v=%b pc=%h want v=1 pc=005", out_valid, out_pc);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h006})
         $display("FAIL jmp_next: got v=%b pc=%h want v=1 pc=006", out_valid, out_pc);
      else passed++;
      pmem[3] = lin(3);
   endtask

   task automatic test_stall();
      restart();
      repeat (4) @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h002})
         $display("FAIL stall_pre: got v=%b pc=%h want v=1 pc=002", out_valid, out_pc);
      else passed++;
      out_ready = 1'b0;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         total++;
         if ({out_valid, out_pc, out_instr} !== {1'b1, 10'h002, lin(2)})
            $display("FAIL stall_hold%0d: got v=%b pc=%h instr=%h want v=1 pc=002 instr=%h",
                     s, out_valid, out_pc, out_instr, lin(2));
         else passed++;
      end
      total++;
      if (dut.u_fifo.count !== 2'd2)
         $display("FAIL stall_count: got %0d want 2", dut.u_fifo.count);
      else passed++;
      out_ready = 1'b1;
      for (int k = 3; k < 7; k++) begin
         @(negedge clk);
         total++;
         if ({out_valid, out_pc} !== {1'b1, 10'(k)})
            $display("FAIL stall_rel%0d: got v=%b pc=%h want v=1 pc=%h", k, out_valid, out_pc, 10'(k));
         else passed++;
      end
   endtask

   task automatic test_redirect_full();
      restart();
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if (dut.u_fifo.count !== 2'd2)
         $display("FAIL redir_full: got %0d want 2", dut.u_fifo.count);
      else passed++;
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h000})
         $display("FAIL redir_head: got v=%b pc=%h want v=1 pc=000", out_valid, out_pc);
      else passed++;
      redirect_v = 1'b1; redirect_pc = 10'h200;
      @(negedge clk);
      total++;
      if ({out_valid, dut.u_fifo.count} !== {1'b0, 2'd0})
         $display("FAIL redir_flush: got v=%b count=%0d want v=0 count=0",
                  out_valid, dut.u_fifo.count);
      else passed++;
      redirect_v = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL redir_gap: got %b want 0", out_valid);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 10'h200, lin(10'h200)})
         $display("FAIL redir_target: got v=%b pc=%h instr=%h want v=1 pc=200 instr=%h",
                  out_valid, out_pc, out_instr, lin(10'h200));
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h201})
         $display("FAIL redir_next: got v=%b pc=%h want v=1 pc=201", out_valid, out_pc);
      else passed++;
   endtask

   task automatic test_redirect_jump();
      pmem[3] = 32'hC000_0005;
      restart();
      repeat (4) @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h002})
         $display("FAIL rj_pre: got v=%b pc=%h want v=1 pc=002", out_valid, out_pc);
      else passed++;
      redirect_v = 1'b1; redirect_pc = 10'h100;
      @(negedge clk);
      redirect_v = 1'b0;
      total++;
      if (out_valid !== 1'b0) $display("FAIL rj_drop: got %b want 0", out_valid);
      else passed++;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL rj_gap: got %b want 0", out_valid);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h100})
         $display("FAIL rj_target: got v=%b pc=%h want v=1 pc=100", out_valid, out_pc);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h101})
         $display("FAIL rj_next: got v=%b pc=%h want v=1 pc=101", out_valid, out_pc);
      else passed++;
      pmem[3] = lin(3);
   endtask

   task automatic test_wrap_reset();
      restart();
      redirect_v = 1'b1; redirect_pc = 10'h3FF;
      @(negedge clk);
      redirect_v = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 10'h3FF, lin(10'h3FF)})
         $display("FAIL wrap_top: got v=%b pc=%h instr=%h want v=1 pc=3ff instr=%h",
                  out_valid, out_pc, out_instr, lin(10'h3FF));
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h000})
         $display("FAIL wrap_zero: got v=%b pc=%h want v=1 pc=000", out_valid, out_pc);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h001})
         $display("FAIL wrap_one: got v=%b pc=%h want v=1 pc=001", out_valid, out_pc);
      else passed++;
      rst = 1'b1;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc, out_instr} !== {1'b0, 10'h000, 32'h0})
         $display("FAIL midrst_clear: got v=%b pc=%h instr=%h want v=0 pc=000 instr=0",
                  out_valid, out_pc, out_instr);
      else passed++;
      rst = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL midrst_gap: got %b want 0", out_valid);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h000})
         $display("FAIL midrst_restart: got v=%b pc=%h want v=1 pc=000", out_valid, out_pc);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h001})
         $display("FAIL midrst_next: got v=%b pc=%h want v=1 pc=001", out_valid, out_pc);
      else passed++;
   endtask

   task automatic test_run_stop();
      restart();
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid, out_pc} !== {1'b1, 10'h000})
         $display("FAIL stop_drain: got v=%b pc=%h want v=1 pc=000", out_valid, out_pc);
      else passed++;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0) $display("FAIL stop_empty: got %b want 0", out_valid);
      else passed++;
      @(negedge clk);
      total++;
      if ({out_valid, mem_pc} !== {1'b0, 10'h001})
         $display("FAIL stop_hold: got v=%b mem_pc=%h want v=0 mem_pc=001", out_valid, mem_pc);
      else passed++;
   endtask

   initial begin
      passed = 0;
      total = 0;
      for (int i = 0; i < 1024; i++) pmem[i] = lin(i);
      rst = 1'b1;
      run = 1'b0;
      out_ready = 1'b1;
      redirect_v = 1'b0;
      redirect_pc = '0;
      test_reset();
      test_linear();
      test_jump();
      test_stall();
      test_redirect_full();
      test_redirect_jump();
      test_wrap_reset();
      test_run_stop();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
